// File: rtl/axil_shared_pkg.sv
// Shared types and AXI response codes for the two-requester AXI-Lite master.
package axil_shared_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_BWAIT = 3'd2,
      ST_RD    = 3'd3,
      ST_RWAIT = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // SLVERR and DECERR both count as a failed access; OKAY/EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
   endfunction

endpackage

// File: rtl/axil_shared_master_arb.sv
// Two-input round-robin arbiter: on a tie the requester not served last wins.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic       grant,
   output logic       grant_valid
);

   logic last_reg;

   always_comb begin
      grant_valid = |req;
      if (req == 2'b11) begin
         grant = ~last_reg;
      end else begin
         grant = req[1];
      end
   end

   // Reset to 1 so requester 0 takes the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_reg <= 1'b1;
      end else if (advance) begin
         last_reg <= grant;
      end
   end

endmodule

// File: rtl/axil_shared_master.sv
// Shares one AXI-Lite slave between two valid/ready requesters, one transaction at a time,
// holding each completed response until its owner accepts it.
module axil_shared_master #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  req_valid_0,
   output logic                  req_ready_0,
   input  logic                  req_write_0,
   input  logic [ADDR_WIDTH-1:0] req_addr_0,
   input  logic [DATA_WIDTH-1:0] req_wdata_0,
   input  logic [STRB_WIDTH-1:0] req_wstrb_0,
   output logic                  resp_valid_0,
   input  logic                  resp_ready_0,
   output logic [DATA_WIDTH-1:0] resp_rdata_0,
   output logic                  resp_err_0,

   input  logic                  req_valid_1,
   output logic                  req_ready_1,
   input  logic                  req_write_1,
   input  logic [ADDR_WIDTH-1:0] req_addr_1,
   input  logic [DATA_WIDTH-1:0] req_wdata_1,
   input  logic [STRB_WIDTH-1:0] req_wstrb_1,
   output logic                  resp_valid_1,
   input  logic                  resp_ready_1,
   output logic [DATA_WIDTH-1:0] resp_rdata_1,
   output logic                  resp_err_1,

   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   import axil_shared_pkg::*;

   logic [1:0]            req_valid;
   logic [1:0]            req_write;
   logic [ADDR_WIDTH-1:0] req_addr  [2];
   logic [DATA_WIDTH-1:0] req_wdata [2];
   logic [STRB_WIDTH-1:0] req_wstrb [2];
   logic [1:0]            resp_ready;
   logic [1:0]            req_ready;
   logic [1:0]            resp_valid;
   logic [1:0]            resp_err;
   logic [DATA_WIDTH-1:0] resp_rdata [2];

   assign req_valid    = {req_valid_1, req_valid_0};
   assign req_write    = {req_write_1, req_write_0};
   assign resp_ready   = {resp_ready_1, resp_ready_0};
   assign req_addr[0]  = req_addr_0;
   assign req_addr[1]  = req_addr_1;
   assign req_wdata[0] = req_wdata_0;
   assign req_wdata[1] = req_wdata_1;
   assign req_wstrb[0] = req_wstrb_0;
   assign req_wstrb[1] = req_wstrb_1;

   state_t                state_reg;
   logic                  owner_reg;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic [STRB_WIDTH-1:0] wstrb_reg;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  err_reg;
   logic                  awvalid_reg;
   logic                  wvalid_reg;
   logic                  arvalid_reg;

   logic grant;
   logic grant_valid;
   logic accept;
   logic aw_done;
   logic w_done;

   rr_arbiter2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (req_valid),
      .advance     (accept),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign accept = (state_reg == ST_IDLE) && grant_valid;

   // A channel counts as done once its valid has dropped or its handshake is happening now.
   assign aw_done = !awvalid_reg || m_axil_awready;
   assign w_done  = !wvalid_reg  || m_axil_wready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= ST_IDLE;
         owner_reg   <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         wstrb_reg   <= '0;
         rdata_reg   <= '0;
         err_reg     <= 1'b0;
         awvalid_reg <= 1'b0;
         wvalid_reg  <= 1'b0;
         arvalid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  owner_reg <= grant;
                  addr_reg  <= req_addr[grant];
                  if (req_write[grant]) begin
                     wdata_reg   <= req_wdata[grant];
                     wstrb_reg   <= req_wstrb[grant];
                     awvalid_reg <= 1'b1;
                     wvalid_reg  <= 1'b1;
                     state_reg   <= ST_WR;
                  end else begin
                     arvalid_reg <= 1'b1;
                     state_reg   <= ST_RD;
                  end
               end
            end
            ST_WR: begin
               if (awvalid_reg && m_axil_awready) begin
                  awvalid_reg <= 1'b0;
               end
               if (wvalid_reg && m_axil_wready) begin
                  wvalid_reg <= 1'b0;
               end
               if (aw_done && w_done) begin
                  state_reg <= ST_BWAIT;
               end
            end
            ST_BWAIT: begin
               if (m_axil_bvalid) begin
                  rdata_reg <= '0;
                  err_reg   <= resp_is_err(m_axil_bresp);
                  state_reg <= ST_RESP;
               end
            end
            ST_RD: begin
               if (m_axil_arready) begin
                  arvalid_reg <= 1'b0;
                  state_reg   <= ST_RWAIT;
               end
            end
            ST_RWAIT: begin
               if (m_axil_rvalid) begin
                  rdata_reg <= m_axil_rdata;
                  err_reg   <= resp_is_err(m_axil_rresp);
                  state_reg <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (resp_ready[owner_reg]) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Response data is steered to the owner only; the other requester sees zeros.
   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi]  = accept && (grant == 1'(gi));
      assign resp_valid[gi] = (state_reg == ST_RESP) && (owner_reg == 1'(gi));
      assign resp_rdata[gi] = (owner_reg == 1'(gi)) ? rdata_reg : '0;
      assign resp_err[gi]   = (owner_reg == 1'(gi)) ? err_reg : 1'b0;
   end

   assign req_ready_0  = req_ready[0];
   assign req_ready_1  = req_ready[1];
   assign resp_valid_0 = resp_valid[0];
   assign resp_valid_1 = resp_valid[1];
   assign resp_rdata_0 = resp_rdata[0];
   assign resp_rdata_1 = resp_rdata[1];
   assign resp_err_0   = resp_err[0];
   assign resp_err_1   = resp_err[1];

   assign m_axil_awaddr  = addr_reg;
   assign m_axil_awprot  = 3'b000;
   assign m_axil_awvalid = awvalid_reg;
   assign m_axil_wdata   = wdata_reg;
   assign m_axil_wstrb   = wstrb_reg;
   assign m_axil_wvalid  = wvalid_reg;
   assign m_axil_bready  = (state_reg == ST_BWAIT);
   assign m_axil_araddr  = addr_reg;
   assign m_axil_arprot  = 3'b000;
   assign m_axil_arvalid = arvalid_reg;
   assign m_axil_rready  = (state_reg == ST_RWAIT);

endmodule

// File: tb/tb_axil_shared_master.sv
// Directed bench for axil_shared_master with a small AXI-Lite RAM model as the slave.
module tb_axil_shared_master;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int SW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [1:0]    req_valid, req_write, resp_ready;
   logic [AW-1:0] req_addr  [2];
   logic [DW-1:0] req_wdata [2];
   logic [SW-1:0] req_wstrb [2];
   wire  [1:0]    req_ready, resp_valid, resp_err;
   wire  [DW-1:0] resp_rdata_0, resp_rdata_1;

   wire [AW-1:0] awaddr, araddr;
   wire [2:0]    awprot, arprot;
   wire          awvalid, wvalid, arvalid, bready, rready;
   wire [DW-1:0] wdata;
   wire [SW-1:0] wstrb;
   wire          awready, wready, arready;
   logic         bvalid, rvalid;
   logic [1:0]   bresp, rresp;
   logic [DW-1:0] rdata;

   int         aw_delay;
   logic [1:0] bresp_force;
   logic       r_stall;
   int         aw_wait;
   logic       got_aw, got_w;
   logic [DW-1:0] mem [8];

   int checks = 0;
   int failures = 0;

   logic mon_clr, mon_en;
   int   rready_cnt, aw_cnt, w_cnt;

   axil_shared_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
      .clk(clk), .rst(rst),
      .req_valid_0(req_valid[0]), .req_ready_0(req_ready[0]), .req_write_0(req_write[0]),
      .req_addr_0(req_addr[0]), .req_wdata_0(req_wdata[0]), .req_wstrb_0(req_wstrb[0]),
      .resp_valid_0(resp_valid[0]), .resp_ready_0(resp_ready[0]),
      .resp_rdata_0(resp_rdata_0), .resp_err_0(resp_err[0]),
      .req_valid_1(req_valid[1]), .req_ready_1(req_ready[1]), .req_write_1(req_write[1]),
      .req_addr_1(req_addr[1]), .req_wdata_1(req_wdata[1]), .req_wstrb_1(req_wstrb[1]),
      .resp_valid_1(resp_valid[1]), .resp_ready_1(resp_ready[1]),
      .resp_rdata_1(resp_rdata_1), .resp_err_1(resp_err[1]),
      .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
      .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
      .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
      .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
      .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
      .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
      .m_axil_rready(rready)
   );

   // Slave: awready after aw_delay cycles of awvalid, wready/arready always high,
   // B the cycle after both write handshakes, R the cycle after AR unless stalled.
   assign awready = (aw_wait >= aw_delay);
   assign wready  = 1'b1;
   assign arready = 1'b1;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         aw_wait <= 0; got_aw <= 1'b0; got_w <= 1'b0;
         bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else begin
         if (awvalid && !awready) aw_wait <= aw_wait + 1;
         else if (awvalid && awready) aw_wait <= 0;
         if (awvalid && awready) got_aw <= 1'b1;
         if (wvalid && wready) got_w <= 1'b1;
         if (!bvalid && (got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
            for (int b = 0; b < SW; b++)
               if (wstrb[b]) mem[awaddr[4:2]][8*b +: 8] <= wdata[8*b +: 8];
            bvalid <= 1'b1;
            bresp  <= bresp_force;
         end
         if (bvalid && bready) begin
            bvalid <= 1'b0; got_aw <= 1'b0; got_w <= 1'b0;
         end
         if (arvalid && arready && !r_stall) begin
            rvalid <= 1'b1; rdata <= mem[araddr[4:2]]; rresp <= 2'b00;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (mon_clr) begin
         rready_cnt <= 0; aw_cnt <= 0; w_cnt <= 0;
      end else if (mon_en) begin
         if (rready)  rready_cnt <= rready_cnt + 1;
         if (awvalid) aw_cnt <= aw_cnt + 1;
         if (wvalid)  w_cnt <= w_cnt + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic set_req(input int who, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_write[who] = wr; req_addr[who] = a; req_wdata[who] = d; req_wstrb[who] = s;
      req_valid[who] = 1'b1;
   endtask

   task automatic wait_resp(input int who, output int c);
      c = 0;
      while (!resp_valid[who] && c < 30) begin
         tick();
         c++;
      end
      check("resp_arrives", {31'd0, resp_valid[who]}, 32'd1);
   endtask

   task automatic run_txn(input int who, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s,
                          output int lat, output logic [DW-1:0] rd, output logic er);
      int c;
      lat = -1; rd = '0; er = 1'b0;
      resp_ready[who] = 1'b1;
      set_req(who, wr, a, d, s);
      #1;
      c = 0;
      while (!req_ready[who] && c < 20) begin
         tick();
         c++;
      end
      if (!req_ready[who]) begin
         check("accept", {31'd0, req_ready[who]}, 32'd1);
         req_valid[who] = 1'b0;
      end else begin
         tick();
         req_valid[who] = 1'b0;
         wait_resp(who, c);
         lat = c + 1;
         rd = (who == 1) ? resp_rdata_1 : resp_rdata_0;
         er = resp_err[who];
         tick();
      end
      $display("txn who=%0d wr=%0d addr=%0d wdata=%h rdata=%h err=%0d lat=%0d",
               who, wr, a, d, rd, er, lat);
   endtask

   typedef struct {
      int            who;
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
      int            exp_lat;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int lat, c;
      logic [DW-1:0] rd;
      logic er;

      vecs[0] = '{0, 1'b1, 5'd1,  32'd20,        4'hf, 32'd0,         1'b0, 3};
      vecs[1] = '{0, 1'b0, 5'd1,  32'd0,         4'h0, 32'd20,        1'b0, 3};
      vecs[2] = '{1, 1'b1, 5'd8,  32'hA5A5_0F0F, 4'hf, 32'd0,         1'b0, 3};
      vecs[3] = '{1, 1'b0, 5'd8,  32'd0,         4'h0, 32'hA5A5_0F0F, 1'b0, 3};
      vecs[4] = '{0, 1'b1, 5'd12, 32'h1122_3344, 4'h5, 32'd0,         1'b0, 3};
      vecs[5] = '{0, 1'b0, 5'd12, 32'd0,         4'h0, 32'h0022_0044, 1'b0, 3};
      vecs[6] = '{1, 1'b0, 5'd16, 32'd0,         4'h0, 32'd0,         1'b0, 3};

      rst = 1'b0; req_valid = '0; req_write = '0; resp_ready = 2'b11;
      for (int i = 0; i < 2; i++) begin
         req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
      end
      aw_delay = 0; bresp_force = 2'b00; r_stall = 1'b0;
      mon_clr = 1'b1; mon_en = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_awvalid", {31'd0, awvalid}, 0);
      check("rst_wvalid",  {31'd0, wvalid}, 0);
      check("rst_arvalid", {31'd0, arvalid}, 0);
      check("rst_bready",  {31'd0, bready}, 0);
      check("rst_rready",  {31'd0, rready}, 0);
      check("rst_resp_valid", {30'd0, resp_valid}, 0);
      check("rst_req_ready",  {30'd0, req_ready}, 0);
      check("rst_resp_err",   {30'd0, resp_err}, 0);
      check("rst_rdata0", resp_rdata_0, 0);
      check("rst_rdata1", resp_rdata_1, 0);
      check("rst_awaddr", {27'd0, awaddr}, 0);
      check("rst_wdata",  wdata, 0);
      check("rst_prot",   {26'd0, awprot, arprot}, 0);
      rst = 1'b1;
      mon_clr = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      end

      // Back-pressure: awready late by two cycles, wready immediate
      mon_clr = 1'b1; tick(); mon_clr = 1'b0; mon_en = 1'b1; aw_delay = 2;
      run_txn(0, 1'b1, 5'd20, 32'hDEAD_BEEF, 4'hf, lat, rd, er);
      mon_en = 1'b0; aw_delay = 0;
      check("bp_lat", lat, 5);
      check("bp_aw_cycles", aw_cnt, 3);
      check("bp_w_cycles", w_cnt, 1);
      check("bp_err", {31'd0, er}, 0);
      run_txn(0, 1'b0, 5'd20, 32'd0, 4'h0, lat, rd, er);
      check("bp_readback", rd, 32'hDEAD_BEEF);

      // Error response on a store
      bresp_force = 2'b10;
      run_txn(0, 1'b1, 5'd24, 32'h1234_5678, 4'hf, lat, rd, er);
      bresp_force = 2'b00;
      check("slverr_err", {31'd0, er}, 1);
      check("slverr_rdata", rd, 0);

      // Stalled requester keeps a stable response
      mon_clr = 1'b1; tick(); mon_clr = 1'b0; mon_en = 1'b1;
      resp_ready[0] = 1'b0;
      set_req(0, 1'b0, 5'd1, 32'd0, 4'h0);
      #1;
      check("stall_accept", {31'd0, req_ready[0]}, 1);
      tick();
      req_valid[0] = 1'b0;
      wait_resp(0, c);
      for (int k = 0; k < 8; k++) begin
         check("stall_valid", {31'd0, resp_valid[0]}, 1);
         check("stall_rdata", resp_rdata_0, 32'd20);
         tick();
      end
      resp_ready[0] = 1'b1;
      tick();
      mon_en = 1'b0;
      check("stall_released", {31'd0, resp_valid[0]}, 0);
      check("stall_rready_cycles", rready_cnt, 1);
      $display("txn who=0 wr=0 addr=1 stalled rdata=%h", 32'd20);

      run_txn(1, 1'b1, 5'd16, 32'h77, 4'hf, lat, rd, er);
      check("r1_store_lat", lat, 3);

      // Contention: r0 store 5 @2 vs r1 load @2; r0 re-requests and loses the second tie
      set_req(0, 1'b1, 5'd2, 32'd5, 4'hf);
      set_req(1, 1'b0, 5'd2, 32'd0, 4'h0);
      #1;
      check("tie1_grant", {30'd0, req_ready}, 2'b01);
      tick();
      set_req(0, 1'b0, 5'd2, 32'd0, 4'h0);
      wait_resp(0, c);
      check("tie1_r0_lat", c + 1, 3);
      check("tie1_r0_rdata", resp_rdata_0, 0);
      tick();
      check("tie2_grant", {30'd0, req_ready}, 2'b10);
      tick();
      req_valid[1] = 1'b0;
      wait_resp(1, c);
      check("tie2_r1_rdata", resp_rdata_1, 32'd5);
      check("tie2_r1_err", {31'd0, resp_err[1]}, 0);
      tick();
      check("tie2_r0_next", {30'd0, req_ready}, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      wait_resp(0, c);
      check("tie2_r0_rdata", resp_rdata_0, 32'd5);
      tick();
      $display("txn contention sequence done");

      // Reset while waiting for R
      r_stall = 1'b1;
      set_req(0, 1'b0, 5'd1, 32'd0, 4'h0);
      #1;
      tick();
      req_valid[0] = 1'b0;
      c = 0;
      while (!rready && c < 20) begin
         tick();
         c++;
      end
      check("rwait_reached", {31'd0, rready}, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_arvalid", {31'd0, arvalid}, 0);
      check("arst_awvalid", {31'd0, awvalid}, 0);
      check("arst_wvalid",  {31'd0, wvalid}, 0);
      check("arst_rready",  {31'd0, rready}, 0);
      check("arst_bready",  {31'd0, bready}, 0);
      check("arst_resp_valid", {30'd0, resp_valid}, 0);
      r_stall = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      $display("txn reset during RWAIT");
      set_req(0, 1'b1, 5'd4, 32'h99, 4'hf);
      set_req(1, 1'b0, 5'd4, 32'd0, 4'h0);
      #1;
      check("post_rst_tie", {30'd0, req_ready}, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      wait_resp(0, c);
      check("post_rst_r0_err", {31'd0, resp_err[0]}, 0);
      tick();
      check("post_rst_r1_grant", {30'd0, req_ready}, 2'b10);
      tick();
      req_valid[1] = 1'b0;
      wait_resp(1, c);
      check("post_rst_r1_rdata", resp_rdata_1, 32'h99);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
